execute_md: RTL

Parametrised successor to the current execute stage of the 5-stage RISC-V pipeline. Adds:
- a wider ALU op set;
- an iterative RV32M multiply/divide unit with a stall handshake back to the hazard unit;
- flush support.

It takes decoded operands and controls from ID/EX, applies forwarding, computes the result, and registers everything into the EX/MEM boundary.

---
 rtl/execute_md_pkg.sv | 35 +++
 rtl/execute_md_if.sv | 46 ++++
 rtl/execute_md_md_unit.sv | 114 +++++++++++
 rtl/execute_md.sv | 109 ++++++++++
 4 files changed

// File: rtl/execute_md_pkg.sv
// Shared encodings for the execute stage: ALU ops, RV32M ops, forward selects, MD FSM states.
// Pure declarations; no timing or backpressure of its own.
package exec_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdState_t;

endpackage

// File: rtl/execute_md_if.sv
// ID/EX to EX/MEM boundary bundle; master drives the E side, slave is the execute stage.
// busyE is the stall request back toward the hazard unit.
interface execute_md_if #(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
);
  logic               regwriteE;
  logic               memrwE;
  logic [1:0]         wbselE;
  logic [3:0]         ALUselE;
  logic               mdvalidE;
  logic [2:0]         mdselE;
  logic               aselE;
  logic               bselE;
  logic [1:0]         forwardAE;
  logic [1:0]         forwardBE;
  logic [XLEN-1:0]    resultW;
  logic [XLEN-1:0]    rd1E;
  logic [XLEN-1:0]    rd2E;
  logic [XLEN-1:0]    imm_exE;
  logic [XLEN-1:0]    pcE;
  logic [XLEN-1:0]    pc4E;
  logic [REGADDR-1:0] rdE;
  logic               flushE;

  logic               regwriteM;
  logic               memrwM;
  logic [1:0]         wbselM;
  logic [XLEN-1:0]    pc4M;
  logic [XLEN-1:0]    ALUresM;
  logic [XLEN-1:0]    data_writeM;
  logic [REGADDR-1:0] rdM;
  logic               busyE;

  modport master (
    output regwriteE, memrwE, wbselE, ALUselE, mdvalidE, mdselE, aselE, bselE,
           forwardAE, forwardBE, resultW, rd1E, rd2E, imm_exE, pcE, pc4E, rdE, flushE,
    input  regwriteM, memrwM, wbselM, pc4M, ALUresM, data_writeM, rdM, busyE
  );

  modport slave (
    input  regwriteE, memrwE, wbselE, ALUselE, mdvalidE, mdselE, aselE, bselE,
           forwardAE, forwardBE, resultW, rd1E, rd2E, imm_exE, pcE, pc4E, rdE, flushE,
    output regwriteM, memrwM, wbselM, pc4M, ALUresM, data_writeM, rdM, busyE
  );
endinterface

// File: rtl/execute_md_md_unit.sv
// Iterative RV32M unit: radix-2 shift-add multiply, restoring divide, one bit per cycle.
// busy for XLEN+1 cycles (1 for div-by-zero/overflow), done for one cycle; flush aborts.
module md_unit
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  mdState_t          state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   dvsr;
  logic [2:0]        opQ;
  logic              neg;

  logic            signedA, signedB, aNeg, bNeg, divZero, divOvf;
  logic [XLEN-1:0] aMag, bMag;

  assign signedA = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  assign signedB = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  assign aNeg    = signedA && a[XLEN-1];
  assign bNeg    = signedB && b[XLEN-1];
  assign aMag    = aNeg ? -a : a;
  assign bMag    = bNeg ? -b : b;
  assign divZero = op[2] && (b == '0);
  assign divOvf  = ((op == MD_DIV) || (op == MD_REM)) &&
                   (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}});

  // acc = {high/remainder, low/quotient}; both algorithms shift through it.
  logic [XLEN:0]     mulSum, divTrial, divDiff;
  logic [2*XLEN-1:0] stepAcc;

  assign mulSum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dvsr} : '0);
  assign divTrial = acc[2*XLEN-1:XLEN-1];
  assign divDiff  = divTrial - {1'b0, dvsr};
  assign stepAcc  = !opQ[2]     ? {mulSum, acc[XLEN-1:1]} :
                    divDiff[XLEN] ? {divTrial[XLEN-1:0], acc[XLEN-2:0], 1'b0} :
                                    {divDiff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  assign prod = neg ? -acc : acc;
  assign quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    result = '0;
    case (opQ)
      MD_MUL:                       result = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result = quo;
      MD_REM, MD_REMU:              result = rem;
      default:                      result = '0;
    endcase
  end

  assign busy = (state == CALC) || ((state == IDLE) && start);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      dvsr  <= '0;
      opQ   <= '0;
      neg   <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          opQ  <= op;
          dvsr <= bMag;
          // Special cases preload acc so the normal result select yields them.
          if (divZero) begin
            acc   <= {a, {XLEN{1'b1}}};
            neg   <= 1'b0;
            state <= DONE;
          end else if (divOvf) begin
            acc   <= {{XLEN{1'b0}}, a};
            neg   <= 1'b0;
            state <= DONE;
          end else begin
            acc   <= {{XLEN{1'b0}}, aMag};
            neg   <= (op[2] && op[1]) ? aNeg : (aNeg ^ bNeg);
            cnt   <= CW'(XLEN - 1);
            state <= CALC;
          end
        end
        CALC: begin
          acc <= stepAcc;
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/execute_md.sv
// Execute stage: forwarding muxes, ALU, optional iterative RV32M unit, EX/MEM register.
// ALU ops reach M in one edge; M ops stall via busyE and insert bubbles until done; flush kills.
module execute_md
  import exec_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5,
  parameter bit MD_EN   = 1'b1
) (
  input logic         clk,
  input logic         rst,
  execute_md_if.slave bus
);
  logic [XLEN-1:0] fwdA, fwdB, opA, opB, aluRes;
  logic [XLEN-1:0] aluResQ, pc4Q, dataWriteQ;
  logic [REGADDR-1:0] rdQ;
  logic [1:0] wbselQ;
  logic regwriteQ, memrwQ;
  logic [$clog2(XLEN)-1:0] shamt;

  always_comb begin
    case (bus.forwardAE)
      FWD_W:   fwdA = bus.resultW;
      FWD_M:   fwdA = aluResQ;
      default: fwdA = bus.rd1E;
    endcase
    case (bus.forwardBE)
      FWD_W:   fwdB = bus.resultW;
      FWD_M:   fwdB = aluResQ;
      default: fwdB = bus.rd2E;
    endcase
  end

  assign opA   = bus.aselE ? bus.pcE : fwdA;
  assign opB   = bus.bselE ? bus.imm_exE : fwdB;
  assign shamt = opB[$clog2(XLEN)-1:0];

  always_comb begin
    aluRes = '0;
    case (bus.ALUselE)
      ALU_ADD:  aluRes = opA + opB;
      ALU_SUB:  aluRes = opA - opB;
      ALU_AND:  aluRes = opA & opB;
      ALU_OR:   aluRes = opA | opB;
      ALU_XOR:  aluRes = opA ^ opB;
      ALU_SLL:  aluRes = opA << shamt;
      ALU_SRL:  aluRes = opA >> shamt;
      ALU_SRA:  aluRes = $unsigned($signed(opA) >>> shamt);
      ALU_SLT:  aluRes = {{(XLEN-1){1'b0}}, $signed(opA) < $signed(opB)};
      ALU_SLTU: aluRes = {{(XLEN-1){1'b0}}, opA < opB};
      default:  aluRes = '0;
    endcase
  end

  logic mdBusy, mdDone;
  logic [XLEN-1:0] mdResult;

  if (MD_EN) begin : gMd
    md_unit #(.XLEN(XLEN)) uMd (
      .clk   (clk),
      .rst   (rst),
      .start (bus.mdvalidE),
      .op    (bus.mdselE),
      .a     (fwdA),
      .b     (fwdB),
      .flush (bus.flushE),
      .busy  (mdBusy),
      .done  (mdDone),
      .result(mdResult)
    );
  end else begin : gNoMd
    assign mdBusy   = 1'b0;
    assign mdDone   = 1'b0;
    assign mdResult = '0;
  end

  // A bubble clears only the side-effecting controls; data fields keep their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwriteQ  <= 1'b0;
      memrwQ     <= 1'b0;
      wbselQ     <= '0;
      pc4Q       <= '0;
      aluResQ    <= '0;
      dataWriteQ <= '0;
      rdQ        <= '0;
    end else if (bus.flushE || mdBusy) begin
      regwriteQ <= 1'b0;
      memrwQ    <= 1'b0;
    end else begin
      regwriteQ  <= bus.regwriteE;
      memrwQ     <= bus.memrwE;
      wbselQ     <= bus.wbselE;
      pc4Q       <= bus.pc4E;
      aluResQ    <= mdDone ? mdResult : aluRes;
      dataWriteQ <= fwdB;
      rdQ        <= bus.rdE;
    end
  end

  assign bus.regwriteM   = regwriteQ;
  assign bus.memrwM      = memrwQ;
  assign bus.wbselM      = wbselQ;
  assign bus.pc4M        = pc4Q;
  assign bus.ALUresM     = aluResQ;
  assign bus.data_writeM = dataWriteQ;
  assign bus.rdM         = rdQ;
  assign bus.busyE       = mdBusy;
endmodule
